crypto_engine: RTL and testbench

CRYPTO_ENGINE -- requirements
Module: crypto_engine

---
 rtl/crypto_pkg.sv | 14 +
 rtl/crypto_round.sv | 41 ++++
 rtl/crypto_engine.sv | 109 ++++++++++
 tb/tb_crypto_engine.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// Shared types and constants for the iterative block cipher engine.
// Holds the controller state encoding and the mode select values.
package crypto_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/crypto_round.sv
// One combinational cipher round (encrypt or decrypt) together with
// derivation of the round key from the base key and the round index.
import crypto_pkg::*;

module crypto_round #(
   parameter int DATA_W = 19,
   parameter int ROT    = 5,
   parameter int CNT_W  = 3
) (
   input  logic              i_mode,
   input  logic [DATA_W-1:0] i_data,
   input  logic [DATA_W-1:0] i_key,
   input  logic [CNT_W-1:0]  i_round,
   output logic [DATA_W-1:0] o_data
);

   logic [31:0]       w_amt;
   logic [DATA_W-1:0] w_rk;
   logic [DATA_W-1:0] w_encMix;
   logic [DATA_W-1:0] w_encRot;
   logic [DATA_W-1:0] w_enc;
   logic [DATA_W-1:0] w_decSub;
   logic [DATA_W-1:0] w_decRot;
   logic [DATA_W-1:0] w_dec;

   // A right shift by the full width yields zero, so rotate-by-zero needs no special case.
   assign w_amt = 32'(i_round) % 32'(DATA_W);
   assign w_rk  = ((i_key << w_amt) | (i_key >> (32'(DATA_W) - w_amt))) ^ DATA_W'(i_round);

   assign w_encMix = i_data ^ w_rk;
   assign w_encRot = {w_encMix[DATA_W-ROT-1:0], w_encMix[DATA_W-1:DATA_W-ROT]};
   assign w_enc    = w_encRot + w_rk;

   // Decrypt undoes the add, then the rotate, then the xor, in reverse order.
   assign w_decSub = i_data - w_rk;
   assign w_decRot = {w_decSub[ROT-1:0], w_decSub[DATA_W-1:ROT]};
   assign w_dec    = w_decRot ^ w_rk;

   assign o_data = (i_mode == MODE_DEC) ? w_dec : w_enc;

endmodule

// File: rtl/crypto_engine.sv
// Iterative cipher engine: latches operands on start, runs one round per
// cycle, then pulses done for one cycle with the registered result.
import crypto_pkg::*;

module crypto_engine #(
   parameter int DATA_W = 19,
   parameter int ROUNDS = 4,
   parameter int ROT    = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] key_in,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam int CNT_W = $clog2(ROUNDS) + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

   state_t            r_state;
   logic              r_ready;
   logic              r_busy;
   logic              r_done;
   logic              r_mode;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_key;
   logic [DATA_W-1:0] r_result;
   logic [DATA_W-1:0] w_roundOut;
   logic              w_lastRound;

   crypto_round #(
      .DATA_W (DATA_W),
      .ROT    (ROT),
      .CNT_W  (CNT_W)
   ) u_round (
      .i_mode  (r_mode),
      .i_data  (r_data),
      .i_key   (r_key),
      .i_round (r_cnt),
      .o_data  (w_roundOut)
   );

   // Encrypt walks round indices upward, decrypt walks them back down to zero.
   assign w_lastRound = (r_mode == MODE_DEC) ? (r_cnt == '0) : (r_cnt == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_mode   <= MODE_ENC;
         r_cnt    <= '0;
         r_data   <= '0;
         r_key    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mode  <= mode;
                  r_data  <= data_in;
                  r_key   <= key_in;
                  r_cnt   <= (mode == MODE_DEC) ? LAST_IDX : '0;
                  r_state <= RUN;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            RUN: begin
               r_data <= w_roundOut;
               if (w_lastRound) begin
                  r_result <= w_roundOut;
                  r_state  <= DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
               end else if (r_mode == MODE_DEC) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign ready  = r_ready;
   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

endmodule

// File: tb/tb_crypto_engine.sv
// Directed and randomized checks of crypto_engine: a default-parameter instance
// plus six instances spanning DATA_W {8,19,32} x ROUNDS {1,16}.
module tb_crypto_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cycleCnt = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [18:0] dataIn = '0;
   logic [18:0] keyIn = '0;
   logic        ready, busy, done;
   logic [18:0] result;

   crypto_engine dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .data_in(dataIn),
      .key_in(keyIn), .ready(ready), .busy(busy), .done(done), .result(result)
   );

   function automatic int cfgDw(int c);
      return (c < 2) ? 8 : ((c < 4) ? 19 : 32);
   endfunction
   function automatic int cfgRounds(int c);
      return (c % 2 == 0) ? 1 : 16;
   endfunction
   function automatic int cfgRot(int c);
      return (c < 2) ? 3 : 5;
   endfunction

   logic [5:0]  rStart = '0;
   logic        rMode = 1'b0;
   logic [31:0] rData = '0;
   logic [31:0] rKey = '0;
   logic [5:0]  rReady, rBusy, rDone;
   logic [31:0] rResult [6];

   for (genvar g = 0; g < 6; g++) begin : gCfg
      localparam int DW = cfgDw(g);
      logic [DW-1:0] res;
      logic rdy, bsy, dn;
      crypto_engine #(.DATA_W(DW), .ROUNDS(cfgRounds(g)), .ROT(cfgRot(g))) u_dut (
         .clk(clk), .rst(rst), .start(rStart[g]), .mode(rMode), .data_in(rData[DW-1:0]),
         .key_in(rKey[DW-1:0]), .ready(rdy), .busy(bsy), .done(dn), .result(res)
      );
      assign rReady[g]  = rdy;
      assign rBusy[g]   = bsy;
      assign rDone[g]   = dn;
      assign rResult[g] = 32'(res);
   end

   // Reference model of the cipher, written from the round equations.
   function automatic logic [63:0] maskOf(int dw);
      return (64'd1 << dw) - 64'd1;
   endfunction
   function automatic logic [63:0] rotlM(logic [63:0] v, int n, int dw);
      if (n == 0) return v & maskOf(dw);
      return ((v << n) | (v >> (dw - n))) & maskOf(dw);
   endfunction
   function automatic logic [63:0] rkM(logic [63:0] key, int r, int dw);
      return rotlM(key & maskOf(dw), r % dw, dw) ^ (64'(r) & maskOf(dw));
   endfunction
   function automatic logic [63:0] encM(logic [63:0] x, logic [63:0] key, int dw, int rounds, int rot);
      logic [63:0] y, k;
      y = x & maskOf(dw);
      for (int r = 0; r < rounds; r++) begin
         k = rkM(key, r, dw);
         y = (rotlM(y ^ k, rot, dw) + k) & maskOf(dw);
      end
      return y;
   endfunction
   function automatic logic [63:0] decM(logic [63:0] x, logic [63:0] key, int dw, int rounds, int rot);
      logic [63:0] y, k;
      y = x & maskOf(dw);
      for (int r = rounds - 1; r >= 0; r--) begin
         k = rkM(key, r, dw);
         y = rotlM((y - k) & maskOf(dw), dw - rot, dw) ^ k;
      end
      return y;
   endfunction

   // Drives one operation on the default instance and observes a fixed window.
   task automatic runOp(input logic m, input logic [18:0] d, input logic [18:0] k,
                        output logic [18:0] res, output int lat, output int busyCnt, output int doneCnt);
      int startCycle;
      @(negedge clk);
      start = 1'b1; mode = m; dataIn = d; keyIn = k;
      startCycle = cycleCnt;
      @(negedge clk);
      start = 1'b0; mode = ~m; dataIn = ~d; keyIn = ~k;
      lat = -1; busyCnt = 0; doneCnt = 0; res = '0;
      for (int i = 0; i < 12; i++) begin
         if (busy) busyCnt++;
         if (done) begin
            doneCnt++;
            if (lat < 0) begin
               lat = cycleCnt - startCycle;
               res = result;
            end
         end
         @(negedge clk);
      end
   endtask

   // Drives one operation on instance c; returns at the negedge where done is seen.
   task automatic runRand(input int c, input logic m, input logic [31:0] d, input logic [31:0] k,
                          output logic [31:0] res, output int lat);
      int startCycle;
      @(negedge clk);
      rStart[c] = 1'b1; rMode = m; rData = d; rKey = k;
      startCycle = cycleCnt;
      @(negedge clk);
      rStart = '0; rMode = ~m; rData = ~d; rKey = ~k;
      lat = -1; res = '0;
      for (int i = 0; i < 40 && lat < 0; i++) begin
         checks++;
         if ($countones({rReady[c], rBusy[c], rDone[c]}) != 1) begin
            errors++;
            $display("[TB] FAIL excl cfg%0d: ready/busy/done=%b%b%b, exactly one required",
                     c, rReady[c], rBusy[c], rDone[c]);
         end
         if (rDone[c]) begin
            lat = cycleCnt - startCycle;
            res = rResult[c];
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset;
      start = 1'b1; dataIn = 19'h7FFFF; keyIn = 19'h1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks += 5;
      if (ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready: got %b want 1", ready); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %b want 0", done); end
      if (result !== 19'h0) begin errors++; $display("[TB] FAIL rst_result: got %h want 0", result); end
      if (rReady !== 6'h3F) begin errors++; $display("[TB] FAIL rst_ready_cfg: got %b want 111111", rReady); end
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_start_ignored busy: got %b want 0", busy); end
      if (ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_start_ignored ready: got %b want 1", ready); end
   endtask

   task automatic test_single_round;
      logic [31:0] res;
      int lat;
      runRand(2, 1'b0, 32'h00001, 32'h0, res, lat);
      checks += 2;
      if (res !== 32'h00020) begin errors++; $display("[TB] FAIL r1_enc: got %h want 00020", res); end
      if (lat !== 2) begin errors++; $display("[TB] FAIL r1_enc_latency: got %0d want 2", lat); end
      runRand(2, 1'b1, 32'h00020, 32'h0, res, lat);
      checks += 2;
      if (res !== 32'h00001) begin errors++; $display("[TB] FAIL r1_dec: got %h want 00001", res); end
      if (lat !== 2) begin errors++; $display("[TB] FAIL r1_dec_latency: got %0d want 2", lat); end
   endtask

   task automatic test_enc_dec;
      logic [18:0] cipher, plain, expCipher;
      int lat, busyCnt, doneCnt;
      expCipher = 19'(encM(64'h5A5A5, 64'h12345, 19, 4, 5));
      checks++;
      if (ready !== 1'b1) begin errors++; $display("[TB] FAIL ed_ready: got %b want 1", ready); end
      runOp(1'b0, 19'h5A5A5, 19'h12345, cipher, lat, busyCnt, doneCnt);
      checks += 4;
      if (cipher !== expCipher) begin errors++; $display("[TB] FAIL enc_result: got %h want %h", cipher, expCipher); end
      if (lat !== 5) begin errors++; $display("[TB] FAIL enc_latency: got %0d want 5", lat); end
      if (busyCnt !== 4) begin errors++; $display("[TB] FAIL enc_busy: got %0d want 4", busyCnt); end
      if (doneCnt !== 1) begin errors++; $display("[TB] FAIL enc_done_count: got %0d want 1", doneCnt); end
      runOp(1'b1, cipher, 19'h12345, plain, lat, busyCnt, doneCnt);
      checks += 4;
      if (plain !== 19'h5A5A5) begin errors++; $display("[TB] FAIL dec_result: got %h want 5a5a5", plain); end
      if (lat !== 5) begin errors++; $display("[TB] FAIL dec_latency: got %0d want 5", lat); end
      if (busyCnt !== 4) begin errors++; $display("[TB] FAIL dec_busy: got %0d want 4", busyCnt); end
      if (doneCnt !== 1) begin errors++; $display("[TB] FAIL dec_done_count: got %0d want 1", doneCnt); end
   endtask

   task automatic test_back_to_back;
      logic [18:0] expRes, res;
      int startCycle, lat, doneCnt;
      expRes = 19'(encM(64'h2468A, 64'h0F0F0, 19, 4, 5));
      @(negedge clk);
      start = 1'b1; mode = 1'b0; dataIn = 19'h2468A; keyIn = 19'h0F0F0;
      startCycle = cycleCnt;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; mode = 1'b1; dataIn = 19'h13579; keyIn = 19'h55555;
      lat = -1; doneCnt = 0; res = '0;
      for (int i = 0; i < 15; i++) begin
         if (done) begin
            doneCnt++;
            if (lat < 0) begin lat = cycleCnt - startCycle; res = result; end
         end
         @(negedge clk);
         start = 1'b0;
      end
      checks += 4;
      if (doneCnt !== 1) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d want 1", doneCnt); end
      if (lat !== 5) begin errors++; $display("[TB] FAIL b2b_latency: got %0d want 5", lat); end
      if (res !== expRes) begin errors++; $display("[TB] FAIL b2b_result: got %h want %h", res, expRes); end
      if (result !== expRes) begin errors++; $display("[TB] FAIL b2b_result_held: got %h want %h", result, expRes); end
   endtask

   task automatic test_reset_abort;
      logic [18:0] res, expRes;
      int lat, busyCnt, doneCnt;
      @(negedge clk);
      start = 1'b1; mode = 1'b0; dataIn = 19'h11111; keyIn = 19'h22222;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks += 3;
      if (ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready: got %b want 1", ready); end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
      if (result !== 19'h0) begin errors++; $display("[TB] FAIL abort_result: got %h want 0", result); end
      doneCnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) doneCnt++;
         @(negedge clk);
      end
      checks++;
      if (doneCnt !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d want 0", doneCnt); end
      expRes = 19'(encM(64'h3C3C3, 64'h0ABCD, 19, 4, 5));
      runOp(1'b0, 19'h3C3C3, 19'h0ABCD, res, lat, busyCnt, doneCnt);
      checks += 2;
      if (res !== expRes) begin errors++; $display("[TB] FAIL after_abort_result: got %h want %h", res, expRes); end
      if (lat !== 5) begin errors++; $display("[TB] FAIL after_abort_latency: got %0d want 5", lat); end
   endtask

   task automatic test_random;
      logic [31:0] x, k, cipher, plain, expCipher;
      int c, dw, lat;
      for (int n = 0; n < 1000; n++) begin
         c  = n % 6;
         dw = cfgDw(c);
         x  = 32'($urandom & maskOf(dw));
         k  = 32'($urandom & maskOf(dw));
         expCipher = 32'(encM(64'(x), 64'(k), dw, cfgRounds(c), cfgRot(c)));
         runRand(c, 1'b0, x, k, cipher, lat);
         checks++;
         if (lat < 0 || cipher !== expCipher) begin
            errors++;
            $display("[TB] FAIL rand_enc cfg%0d: got %h lat %0d want %h", c, cipher, lat, expCipher);
         end
         runRand(c, 1'b1, cipher, k, plain, lat);
         checks++;
         if (lat < 0 || plain !== x) begin
            errors++;
            $display("[TB] FAIL rand_roundtrip cfg%0d: got %h lat %0d want %h", c, plain, lat, x);
         end
      end
      checks++;
      if (32'(decM(64'(expCipher), 64'(k), dw, cfgRounds(c), cfgRot(c))) !== x) begin
         errors++;
         $display("[TB] FAIL model_inverse: got %h want %h",
                  32'(decM(64'(expCipher), 64'(k), dw, cfgRounds(c), cfgRot(c))), x);
      end
   endtask

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_single_round();
      test_enc_dec();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
